// File: rtl/spi_dispatch_pkg.sv
// spi_dispatch_pkg
//   Shared types for the SPI command dispatcher: FSM state encoding, the
//   queued command record, opcode constants and the checksum helper.
//   data[4] is the first payload word received on SPI; data[0] the last.
package spi_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SEND  = 2'd2
   } state_t;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam int         MAX_WORDS = 5;
   localparam int         CMD_W     = 16;

   typedef struct packed {
      logic [7:0]                      opcode;
      logic [MAX_WORDS-1:0][CMD_W-1:0] data;
   } cmd_t;

   // XOR of the zero-extended opcode and the four streamable words.
   function automatic logic [CMD_W-1:0] csum_calc(input cmd_t c);
      return {8'h00, c.opcode} ^ c.data[4] ^ c.data[3] ^ c.data[2] ^ c.data[1];
   endfunction

endpackage

// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue
//   Synchronous FIFO of whole commands (cmd_t). Read data is presented
//   combinationally from the head entry. A push while full is accepted only
//   when a pop happens in the same cycle (the slot being vacated is reused).
// Ports:
//   clk_sys, rstb   clock, async active-low reset
//   push, din       push request and command
//   pop, dout       pop request and head command
//   push_acc        push was accepted this cycle
//   full, empty     occupancy flags
module spi_cmd_queue
   import spi_dispatch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk_sys,
   input  logic rstb,
   input  logic push,
   input  cmd_t din,
   input  logic pop,
   output cmd_t dout,
   output logic push_acc,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pop_acc;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_acc  = pop && !empty;
   assign push_acc = push && (!full || pop_acc);
   assign dout     = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_acc, pop_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers decide what is valid.
   always_ff @(posedge clk_sys) begin
      if (push_acc) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/spi_cmd_dispatch.sv
// spi_cmd_dispatch
//   Buffers deframed SPI commands in a small queue, decodes the opcode and
//   streams N = opcode[2:0] payload words (SPI arrival order) on a
//   valid/ready word interface. Illegal opcodes and queue overflow pulse
//   error flags; NOP (0x00) is silently retired.
// Build option:
//   SPI_DISPATCH_CSUM_EN  data[0] carries a checksum; mismatches pulse
//                         err_csum and N = 5 becomes illegal.
// Ports:
//   clk_sys, rstb               clock, async active-low reset
//   cmd_valid/opcode/data       command from the deframer (1-cycle pulse)
//   out_valid/ready/word        payload stream
//   out_opcode/idx/last         beat side-band, stable while stalled
//   busy                        FSM active or queue not empty
//   cmd_drop, err_opcode        1-cycle error pulses
//   err_csum                    1-cycle pulse (checksum build only)
module spi_cmd_dispatch
   import spi_dispatch_pkg::*;
#(
   parameter int CMD_DEPTH = 2,
   parameter int WORD_W    = 16
) (
   input  logic              clk_sys,
   input  logic              rstb,
   input  logic              cmd_valid,
   input  logic [7:0]        cmd_opcode,
   input  logic [WORD_W-1:0] cmd_data [4:0],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_word,
   output logic [7:0]        out_opcode,
   output logic [2:0]        out_idx,
   output logic              out_last,
   output logic              busy,
   output logic              cmd_drop,
   output logic              err_opcode
`ifdef SPI_DISPATCH_CSUM_EN
   ,
   output logic              err_csum
`endif
);

`ifdef SPI_DISPATCH_CSUM_EN
   // The checksum word itself is never streamed.
   localparam logic [2:0] MAX_N = 3'(MAX_WORDS - 1);
`else
   localparam logic [2:0] MAX_N = 3'(MAX_WORDS);
`endif

   state_t state;
   cmd_t   work;
   cmd_t   q_din;
   cmd_t   q_dout;
   logic   q_pop;
   logic   q_push_acc;
   logic   q_full;
   logic   q_empty;

   always_comb begin
      q_din        = '0;
      q_din.opcode = cmd_opcode;
      for (int i = 0; i < MAX_WORDS; i++) q_din.data[i] = cmd_data[i];
   end

   // Only IDLE drains the queue, one whole command at a time.
   assign q_pop = (state == IDLE) && !q_empty;

   spi_cmd_queue #(.DEPTH(CMD_DEPTH)) u_queue (
      .clk_sys  (clk_sys),
      .rstb     (rstb),
      .push     (cmd_valid),
      .din      (q_din),
      .pop      (q_pop),
      .dout     (q_dout),
      .push_acc (q_push_acc),
      .full     (q_full),
      .empty    (q_empty)
   );

   // Decode of the command held in the working registers.
   logic [2:0] w_n;
   logic       w_nop;
   logic       w_illegal;
   logic [2:0] next_idx;

   assign w_n       = work.opcode[2:0];
   assign w_nop     = (work.opcode == OP_NOP);
   assign w_illegal = !w_nop && ((w_n == 3'd0) || (w_n > MAX_N));
   assign next_idx  = out_idx + 3'd1;

`ifdef SPI_DISPATCH_CSUM_EN
   logic w_csum_bad;
   assign w_csum_bad = (work.data[0] != csum_calc(work));
`endif

   assign busy = (state != IDLE) || !q_empty;

   always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) begin
         state      <= IDLE;
         work       <= '0;
         out_valid  <= 1'b0;
         out_word   <= '0;
         out_opcode <= '0;
         out_idx    <= '0;
         out_last   <= 1'b0;
         cmd_drop   <= 1'b0;
         err_opcode <= 1'b0;
`ifdef SPI_DISPATCH_CSUM_EN
         err_csum   <= 1'b0;
`endif
      end else begin
         cmd_drop   <= cmd_valid && !q_push_acc;
         err_opcode <= 1'b0;
`ifdef SPI_DISPATCH_CSUM_EN
         err_csum   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (!q_empty) begin
                  work  <= q_dout;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (w_nop) begin
                  state <= IDLE;
               end else if (w_illegal) begin
                  err_opcode <= 1'b1;
                  state      <= IDLE;
               end
`ifdef SPI_DISPATCH_CSUM_EN
               else if (w_csum_bad) begin
                  err_csum <= 1'b1;
                  state    <= IDLE;
               end
`endif
               else begin
                  // First beat is registered here so out_valid rises with SEND.
                  out_valid  <= 1'b1;
                  out_word   <= work.data[4];
                  out_opcode <= work.opcode;
                  out_idx    <= 3'd0;
                  out_last   <= (w_n == 3'd1);
                  state      <= SEND;
               end
            end
            SEND: begin
               // Outputs only move on a handshake, so they hold during stalls.
               if (out_ready) begin
                  if (out_last) begin
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     out_word   <= '0;
                     out_opcode <= '0;
                     out_idx    <= '0;
                     state      <= IDLE;
                  end else begin
                     out_idx  <= next_idx;
                     out_word <= work.data[3'd4 - next_idx];
                     out_last <= (next_idx == w_n - 3'd1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
module tb_spi_cmd_dispatch;

   logic        clk_sys = 1'b0;
   logic        rstb = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_opcode = 8'h00;
   logic [15:0] cmd_data [4:0];
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_word;
   logic [7:0]  out_opcode;
   logic [2:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        cmd_drop;
   logic        err_opcode;
`ifdef SPI_DISPATCH_CSUM_EN
   logic        err_csum;
   localparam int MAXN = 4;
`else
   localparam int MAXN = 5;
`endif

   spi_cmd_dispatch #(.CMD_DEPTH(2), .WORD_W(16)) dut (
      .clk_sys    (clk_sys),
      .rstb       (rstb),
      .cmd_valid  (cmd_valid),
      .cmd_opcode (cmd_opcode),
      .cmd_data   (cmd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_word   (out_word),
      .out_opcode (out_opcode),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .busy       (busy),
      .cmd_drop   (cmd_drop),
      .err_opcode (err_opcode)
`ifdef SPI_DISPATCH_CSUM_EN
      ,
      .err_csum   (err_csum)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [7:0]  op;
      logic [15:0] w;
      logic [2:0]  idx;
      logic        last;
   } beat_t;

   beat_t exp_q [$];
   int n_chk = 0, n_err = 0;
   int seen_err = 0, seen_drop = 0, seen_csum = 0;
   int exp_err = 0, exp_drop = 0, exp_csum = 0;
   int ready_mode = 0, pat = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] csum_of(input logic [7:0] op, input logic [4:0][15:0] d);
      return {8'h00, op} ^ d[4] ^ d[3] ^ d[2] ^ d[1];
   endfunction

   // What an accepted command must produce, straight from the opcode rules.
   task automatic model_cmd(input logic [7:0] op, input logic [4:0][15:0] d);
      int n;
      n = int'(op[2:0]);
      if (op == 8'h00) return;
      if (n == 0 || n > MAXN) begin exp_err++; return; end
`ifdef SPI_DISPATCH_CSUM_EN
      if (d[0] != csum_of(op, d)) begin exp_csum++; return; end
`endif
      for (int i = 0; i < n; i++)
         exp_q.push_back('{op, d[4-i], 3'(i), (i == n-1)});
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_sys);
      #1;
      case (ready_mode)
         1: begin out_ready = (pat % 3 == 0); pat++; end
         2: out_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [4:0][15:0] d, input bit accepted);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      for (int i = 0; i < 5; i++) cmd_data[i] = d[i];
      tick();
      cmd_valid = 1'b0;
      if (accepted) model_cmd(op, d);
      else exp_drop++;
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 400; k++) begin
         if (!busy && !out_valid) break;
         tick();
      end
      chk(tag, {31'b0, busy | out_valid}, 32'd0);
      tick();
      tick();
   endtask

   // ---------------- monitor (samples on the falling edge) ----------------
   logic        prev_stall = 1'b0;
   logic [15:0] pw;
   logic [7:0]  po;
   logic [2:0]  pi;
   beat_t       mb;

   always @(negedge clk_sys) begin
      if (!rstb) begin
         prev_stall = 1'b0;
      end else begin
         if (err_opcode) seen_err++;
         if (cmd_drop) seen_drop++;
`ifdef SPI_DISPATCH_CSUM_EN
         if (err_csum) seen_csum++;
`endif
         if (prev_stall) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_word", {16'b0, out_word}, {16'b0, pw});
            chk("hold_idx", {29'b0, out_idx}, {29'b0, pi});
            chk("hold_opcode", {24'b0, out_opcode}, {24'b0, po});
         end
         if (out_valid && out_ready) begin
            chk("beat_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               mb = exp_q.pop_front();
               chk("beat_word", {16'b0, out_word}, {16'b0, mb.w});
               chk("beat_idx", {29'b0, out_idx}, {29'b0, mb.idx});
               chk("beat_opcode", {24'b0, out_opcode}, {24'b0, mb.op});
               chk("beat_last", {31'b0, out_last}, {31'b0, mb.last});
            end
         end
         prev_stall = out_valid && !out_ready;
         pw = out_word;
         po = out_opcode;
         pi = out_idx;
      end
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [4:0][15:0] d;
      logic [7:0] op;
      int k;

      for (int i = 0; i < 5; i++) cmd_data[i] = 16'h0;
      d = {16'hA000, 16'hB001, 16'hC002, 16'hD003, 16'hE004};

      // Reset state
      tick(); tick();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_word", {16'b0, out_word}, 32'd0);
      chk("rst_out_opcode", {24'b0, out_opcode}, 32'd0);
      chk("rst_out_idx", {29'b0, out_idx}, 32'd0);
      chk("rst_out_last", {31'b0, out_last}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_flags", {30'b0, cmd_drop, err_opcode}, 32'd0);
      rstb = 1'b1;
      tick(); tick();

      // Opcode 0x03: latency E0 -> valid after E2, three beats
`ifdef SPI_DISPATCH_CSUM_EN
      d[0] = csum_of(8'h03, d);
`endif
      out_ready = 1'b1;
      send_cmd(8'h03, d, 1'b1);
      chk("lat_e0", {31'b0, out_valid}, 32'd0);
      tick();
      chk("lat_e1", {31'b0, out_valid}, 32'd0);
      tick();
      chk("lat_e2_valid", {31'b0, out_valid}, 32'd1);
      chk("lat_e2_word", {16'b0, out_word}, 32'h0000A000);
      chk("lat_e2_opcode", {24'b0, out_opcode}, 32'h03);
      wait_idle("idle_op3");
      chk("op3_all_beats", exp_q.size(), 32'd0);

      // Opcode 0x05 with out_ready pattern 1,0,0 (stalls)
      d = {16'hA000, 16'hB001, 16'hC002, 16'hD003, 16'hE004};
      ready_mode = 1;
      pat = 0;
      send_cmd(8'h05, d, 1'b1);
      wait_idle("idle_op5");
      chk("op5_all_beats", exp_q.size(), 32'd0);
      ready_mode = 0;
      out_ready = 1'b1;

      // Illegal opcodes and NOP
      send_cmd(8'h06, d, 1'b1);
      wait_idle("idle_op06");
      send_cmd(8'h10, d, 1'b1);
      wait_idle("idle_op10");
      chk("err_opcode_cnt", seen_err, exp_err);
      send_cmd(8'h00, d, 1'b1);
      wait_idle("idle_nop");
      chk("nop_no_err", seen_err, exp_err);

      // Overflow: A stalled in SEND, B and C fill the queue, D is dropped
      out_ready = 1'b0;
      send_cmd(8'h01, {16'h1111, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1);
      tick(); tick(); tick(); tick();
      chk("a_stalled", {31'b0, out_valid}, 32'd1);
      send_cmd(8'h02, {16'h2220, 16'h2221, 16'h0, 16'h0, 16'h0}, 1'b1);
      send_cmd(8'h01, {16'h3330, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1);
      send_cmd(8'h03, {16'h4440, 16'h4441, 16'h4442, 16'h0, 16'h0}, 1'b0);
      tick(); tick();
      chk("drop_cnt", seen_drop, exp_drop);
      chk("busy_full", {31'b0, busy}, 32'd1);
      // Push into a full queue on the very cycle IDLE pops it: accepted
      out_ready = 1'b1;
      tick();
      send_cmd(8'h02, {16'h5550, 16'h5551, 16'h0, 16'h0, 16'h0}, 1'b1);
      wait_idle("idle_overflow");
      chk("drop_cnt_after_pushpop", seen_drop, exp_drop);
      chk("overflow_all_beats", exp_q.size(), 32'd0);

      // Reset in the middle of a long command
      op = 8'(MAXN);
      d = {16'hA000, 16'hB001, 16'hC002, 16'hD003, 16'hE004};
`ifdef SPI_DISPATCH_CSUM_EN
      d[0] = csum_of(op, d);
`endif
      send_cmd(op, d, 1'b1);
      for (k = 0; k < 20; k++) begin
         tick();
         if (out_valid && out_idx == 3'd2) break;
      end
      chk("rst_mid_at_beat2", {29'b0, out_idx}, 32'd2);
      chk("rst_mid_remaining", exp_q.size(), MAXN - 2);
      rstb = 1'b0;
      #1;
      chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_mid_word", {16'b0, out_word}, 32'd0);
      chk("rst_mid_idx", {28'b0, out_last, out_idx}, 32'd0);
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      exp_q.delete();
      tick(); tick();
      rstb = 1'b1;
      tick();
      send_cmd(8'h01, {16'h7777, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1);
      wait_idle("idle_after_rst");
      chk("after_rst_beats", exp_q.size(), 32'd0);

`ifdef SPI_DISPATCH_CSUM_EN
      // Checksum: good command streams 4 words, 1-bit error is rejected
      d = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0};
      d[0] = csum_of(8'h04, d);
      send_cmd(8'h04, d, 1'b1);
      wait_idle("idle_csum_ok");
      d[0] = d[0] ^ 16'h0001;
      send_cmd(8'h04, d, 1'b1);
      wait_idle("idle_csum_bad");
      chk("csum_err_cnt", seen_csum, exp_csum);
      chk("csum_beats", exp_q.size(), 32'd0);
`endif

      // Randomized commands with random back-pressure, bursts of 1-2
      ready_mode = 2;
      for (int r = 0; r < 24; r++) begin
         int burst;
         burst = $urandom_range(1, 2);
         for (int b = 0; b < burst; b++) begin
            for (int i = 0; i < 5; i++) d[i] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) op = 8'($urandom);
            else op = {5'($urandom), 3'($urandom_range(1, 5))};
            if ($urandom_range(0, 1) == 1) d[0] = csum_of(op, d);
            send_cmd(op, d, 1'b1);
         end
         wait_idle("idle_random");
      end
      ready_mode = 0;
      chk("rand_beats_drained", exp_q.size(), 32'd0);
      chk("final_err_opcode", seen_err, exp_err);
      chk("final_drop", seen_drop, exp_drop);
      chk("final_csum", seen_csum, exp_csum);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
